// File: rtl/wb_bus_pkg.sv
// wb_bus_pkg: shared state type and sizing helper for the Wishbone shared bus
package wb_bus_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, ABORT} bus_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: combinational round-robin pick of the first requester after the last owner
module wb_rr_arbiter
    import wb_bus_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    localparam int IW = idx_w(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IW-1:0]          last,
    output logic [IW-1:0]          next,
    output logic                   valid
);

    // scan from the farthest distance inward so the nearest requester after last wins
    always_comb begin
        next = '0;
        valid = 1'b0;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            if (req[IW'((int'(last) + k) % NUM_MASTERS)]) begin
                next = IW'((int'(last) + k) % NUM_MASTERS);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_shared_bus.sv
// wb_shared_bus: round-robin Wishbone shared bus with LOCK support and watchdog abort
module wb_shared_bus
    import wb_bus_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int ADR_W = 32,
    parameter int DAT_W = 64,
    parameter int TGD_W = 16,
    parameter int TIMEOUT = 255,
    localparam int SEL_W = DAT_W / 8
) (
    input  logic                         CLK_I,
    input  logic                         RST_I,
    input  logic [NUM_MASTERS-1:0]       m_CYC_I,
    input  logic [NUM_MASTERS-1:0]       m_STB_I,
    input  logic [NUM_MASTERS-1:0]       m_WE_I,
    input  logic [NUM_MASTERS-1:0]       m_LOCK_I,
    input  logic [NUM_MASTERS*ADR_W-1:0] m_ADR_I,
    input  logic [NUM_MASTERS*SEL_W-1:0] m_SEL_I,
    input  logic [NUM_MASTERS*DAT_W-1:0] m_DAT_I,
    input  logic [NUM_MASTERS*TGD_W-1:0] m_TGD_I,
    output logic [DAT_W-1:0]             m_DAT_O,
    output logic [TGD_W-1:0]             m_TGD_O,
    output logic [NUM_MASTERS-1:0]       m_ACK_O,
    output logic [NUM_MASTERS-1:0]       m_ERR_O,
    output logic [NUM_MASTERS-1:0]       m_RTY_O,
    output logic                         s_CYC_O,
    output logic                         s_STB_O,
    output logic                         s_WE_O,
    output logic                         s_LOCK_O,
    output logic [ADR_W-1:0]             s_ADR_O,
    output logic [SEL_W-1:0]             s_SEL_O,
    output logic [DAT_W-1:0]             s_DAT_O,
    output logic [TGD_W-1:0]             s_TGD_O,
    input  logic [DAT_W-1:0]             s_DAT_I,
    input  logic [TGD_W-1:0]             s_TGD_I,
    input  logic                         s_ACK_I,
    input  logic                         s_ERR_I,
    input  logic                         s_RTY_I,
    output logic [NUM_MASTERS-1:0]       gnt_o,
    output logic                         timeout_o
);

    localparam int IW = idx_w(NUM_MASTERS);
    localparam int CW = idx_w(TIMEOUT + 1);

    bus_state_t state, state_nx;
    logic [IW-1:0] owner, owner_nx, last, last_nx, arb_next;
    logic [CW-1:0] cnt;
    logic [NUM_MASTERS-1:0] onehot;
    logic arb_valid, held, live, term, hit, abort, rel;
    logic [ADR_W-1:0] adr [NUM_MASTERS];
    logic [SEL_W-1:0] sel [NUM_MASTERS];
    logic [DAT_W-1:0] dat [NUM_MASTERS];
    logic [TGD_W-1:0] tgd [NUM_MASTERS];

    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
        assign adr[i] = m_ADR_I[i*ADR_W +: ADR_W];
        assign sel[i] = m_SEL_I[i*SEL_W +: SEL_W];
        assign dat[i] = m_DAT_I[i*DAT_W +: DAT_W];
        assign tgd[i] = m_TGD_I[i*TGD_W +: TGD_W];
    end

    wb_rr_arbiter #(.NUM_MASTERS(NUM_MASTERS)) u_arb (
        .req   (m_CYC_I),
        .last  (held ? owner : last),
        .next  (arb_next),
        .valid (arb_valid)
    );

    assign held = state != IDLE;
    assign live = state == BUSY;
    assign onehot = NUM_MASTERS'(1) << owner;
    assign gnt_o = held ? onehot : '0;

    // the grant survives ABORT so the owner keeps its data path, but the slave sees the cycle end
    assign s_CYC_O = live && m_CYC_I[owner];
    assign s_STB_O = live && m_STB_I[owner];
    assign s_WE_O = held && m_WE_I[owner];
    assign s_LOCK_O = held && m_LOCK_I[owner];
    assign s_ADR_O = held ? adr[owner] : '0;
    assign s_SEL_O = held ? sel[owner] : '0;
    assign s_DAT_O = held ? dat[owner] : '0;
    assign s_TGD_O = held ? tgd[owner] : '0;
    assign m_DAT_O = s_DAT_I;
    assign m_TGD_O = s_TGD_I;

    // a real termination in the hit cycle beats the watchdog
    assign term = s_ACK_I || s_ERR_I || s_RTY_I;
    assign hit = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT));
    assign abort = s_STB_O && !term && hit;
    assign rel = !m_CYC_I[owner] && (state == ABORT || !m_LOCK_I[owner]);

    assign m_ACK_O = (live && s_ACK_I) ? onehot : '0;
    assign m_ERR_O = ((live && s_ERR_I) || abort) ? onehot : '0;
    assign m_RTY_O = (live && s_RTY_I) ? onehot : '0;
    assign timeout_o = abort;

    // next owner: grant from idle, or hand over straight away when the owner releases
    always_comb begin
        state_nx = state;
        owner_nx = owner;
        last_nx = last;
        if (abort)
            state_nx = ABORT;
        else if (!held || rel) begin
            state_nx = arb_valid ? BUSY : IDLE;
            owner_nx = arb_valid ? arb_next : owner;
            last_nx = held ? owner : last;
        end
    end

    // state, owner pointers and stall counter
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state <= IDLE;
            owner <= '0;
            last <= IW'(NUM_MASTERS - 1);
            cnt <= '0;
        end else begin
            state <= state_nx;
            owner <= owner_nx;
            last <= last_nx;
            cnt <= (s_STB_O && !term && !abort) ? cnt + 1'b1 : '0;
        end
    end

endmodule

// File: tb/tb_wb_shared_bus.sv
// tb_wb_shared_bus: table vectors, corner sequences and randomized model check for wb_shared_bus
module tb_wb_shared_bus;

    localparam int N = 4;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int TW = 16;
    localparam int SW = DW / 8;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst;
    logic [N-1:0] cyc, stb, we, lock;
    logic [N*AW-1:0] adr;
    logic [N*SW-1:0] sel;
    logic [N*DW-1:0] dat;
    logic [N*TW-1:0] tgd;
    logic [DW-1:0] mdat, sdat, sdat_i;
    logic [TW-1:0] mtgd, stgd, stgd_i;
    logic [N-1:0] mack, merr, mrty, gnt;
    logic scyc, sstb, swe, slock, sack, serr, srty, tmo;
    logic [AW-1:0] sadr, ea;
    logic [SW-1:0] ssel;

    int checks = 0;
    int failures = 0;

    int o_own, o_last, o_stall;
    bit o_abt;

    typedef struct {
        logic [N-1:0] cyc;
        logic [N-1:0] lock;
        logic [2:0]   rsp;
        logic [N-1:0] gnt;
        logic         scyc;
        logic [N-1:0] ack;
        logic [N-1:0] err;
        logic [N-1:0] rty;
    } vec_t;
    vec_t tbl [24];

    always #5 clk = ~clk;

    wb_shared_bus #(
        .NUM_MASTERS(N), .ADR_W(AW), .DAT_W(DW), .TGD_W(TW), .TIMEOUT(TO)
    ) dut (
        .CLK_I(clk), .RST_I(rst),
        .m_CYC_I(cyc), .m_STB_I(stb), .m_WE_I(we), .m_LOCK_I(lock),
        .m_ADR_I(adr), .m_SEL_I(sel), .m_DAT_I(dat), .m_TGD_I(tgd),
        .m_DAT_O(mdat), .m_TGD_O(mtgd),
        .m_ACK_O(mack), .m_ERR_O(merr), .m_RTY_O(mrty),
        .s_CYC_O(scyc), .s_STB_O(sstb), .s_WE_O(swe), .s_LOCK_O(slock),
        .s_ADR_O(sadr), .s_SEL_O(ssel), .s_DAT_O(sdat), .s_TGD_O(stgd),
        .s_DAT_I(sdat_i), .s_TGD_I(stgd_i),
        .s_ACK_I(sack), .s_ERR_I(serr), .s_RTY_I(srty),
        .gnt_o(gnt), .timeout_o(tmo)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc = '0;
        stb = '0;
        lock = '0;
        {sack, serr, srty} = 3'b000;
        tick();
        rst = 1'b0;
    endtask

    // first requester after 'from', wrapping; -1 when nobody asks
    function automatic int pick(input int from, input logic [N-1:0] req);
        for (int k = 1; k <= N; k++)
            if (req[(from + k) % N]) return (from + k) % N;
        return -1;
    endfunction

    function automatic bit timeout_now();
        return o_own >= 0 && !o_abt && stb[o_own] && !(sack || serr || srty) && o_stall == TO;
    endfunction

    task automatic model_check();
        logic [N-1:0] oh;
        bit held, live, to;
        int o;
        held = o_own >= 0;
        o = held ? o_own : 0;
        live = held && !o_abt;
        oh = held ? N'(1) << o : '0;
        to = timeout_now();
        chk("rnd_gnt", gnt, oh);
        chk("rnd_scyc", scyc, live && cyc[o]);
        chk("rnd_sstb", sstb, live && stb[o]);
        chk("rnd_swe", swe, held && we[o]);
        chk("rnd_slock", slock, held && lock[o]);
        chk("rnd_sadr", sadr, held ? adr[o*AW +: AW] : '0);
        chk("rnd_ssel", ssel, held ? sel[o*SW +: SW] : '0);
        chk("rnd_sdat", sdat, held ? dat[o*DW +: DW] : '0);
        chk("rnd_stgd", stgd, held ? tgd[o*TW +: TW] : '0);
        chk("rnd_ack", mack, (live && sack) ? oh : '0);
        chk("rnd_err", merr, ((live && serr) || to) ? oh : '0);
        chk("rnd_rty", mrty, (live && srty) ? oh : '0);
        chk("rnd_tmo", tmo, to);
        chk("rnd_mdat", mdat, sdat_i);
        chk("rnd_mtgd", mtgd, stgd_i);
    endtask

    task automatic model_step();
        bit live, to, term;
        to = timeout_now();
        live = o_own >= 0 && !o_abt;
        term = sack || serr || srty;
        if (o_own < 0)
            o_own = pick(o_last, cyc);
        else if (to) begin
            o_abt = 1'b1;
            o_stall = 0;
        end else begin
            o_stall = (live && stb[o_own] && !term) ? o_stall + 1 : 0;
            if (!cyc[o_own] && (o_abt || !lock[o_own])) begin
                o_last = o_own;
                o_abt = 1'b0;
                o_own = pick(o_own, cyc);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            adr[i*AW +: AW] = 32'hA000_0000 + 32'(i) * 32'h100;
            sel[i*SW +: SW] = 8'h0F << i;
            dat[i*DW +: DW] = {$urandom, $urandom};
            tgd[i*TW +: TW] = 16'($urandom);
        end
        we = 4'b0101;
        sdat_i = 64'h0123_4567_89AB_CDEF;
        stgd_i = 16'hBEEF;

        // reset state with active requests and responses on the wires
        rst = 1'b1;
        cyc = '1;
        stb = '1;
        lock = '0;
        {sack, serr, srty} = 3'b011;
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_scyc", scyc, 0);
        chk("rst_sstb", sstb, 0);
        chk("rst_sadr", sadr, 0);
        chk("rst_ack", mack, 0);
        chk("rst_err", merr, 0);
        chk("rst_tmo", tmo, 0);
        chk("rst_mdat", mdat, 64'h0123_4567_89AB_CDEF);
        do_reset();

        // fairness, single request, lock, routing of each termination kind
        tbl[0]  = '{4'b1111, 4'b0000, 3'b000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000};
        tbl[1]  = '{4'b1111, 4'b0000, 3'b001, 4'b0001, 1'b1, 4'b0001, 4'b0000, 4'b0000};
        tbl[2]  = '{4'b1110, 4'b0000, 3'b000, 4'b0001, 1'b0, 4'b0000, 4'b0000, 4'b0000};
        tbl[3]  = '{4'b1111, 4'b0000, 3'b001, 4'b0010, 1'b1, 4'b0010, 4'b0000, 4'b0000};
        tbl[4]  = '{4'b1101, 4'b0000, 3'b000, 4'b0010, 1'b0, 4'b0000, 4'b0000, 4'b0000};
        tbl[5]  = '{4'b1111, 4'b0000, 3'b001, 4'b0100, 1'b1, 4'b0100, 4'b0000, 4'b0000};
        tbl[6]  = '{4'b1011, 4'b0000, 3'b000, 4'b0100, 1'b0, 4'b0000, 4'b0000, 4'b0000};
        tbl[7]  = '{4'b1111, 4'b0000, 3'b001, 4'b1000, 1'b1, 4'b1000, 4'b0000, 4'b0000};
        tbl[8]  = '{4'b0111, 4'b0000, 3'b000, 4'b1000, 1'b0, 4'b0000, 4'b0000, 4'b0000};
        tbl[9]  = '{4'b0001, 4'b0000, 3'b000, 4'b0001, 1'b1, 4'b0000, 4'b0000, 4'b0000};
        tbl[10] = '{4'b0000, 4'b0000, 3'b000, 4'b0001, 1'b0, 4'b0000, 4'b0000, 4'b0000};
        tbl[11] = '{4'b0000, 4'b0000, 3'b000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000};
        tbl[12] = '{4'b0100, 4'b0000, 3'b000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000};
        tbl[13] = '{4'b0100, 4'b0000, 3'b001, 4'b0100, 1'b1, 4'b0100, 4'b0000, 4'b0000};
        tbl[14] = '{4'b0000, 4'b0000, 3'b000, 4'b0100, 1'b0, 4'b0000, 4'b0000, 4'b0000};
        tbl[15] = '{4'b0010, 4'b0010, 3'b000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000};
        tbl[16] = '{4'b1010, 4'b0010, 3'b001, 4'b0010, 1'b1, 4'b0010, 4'b0000, 4'b0000};
        tbl[17] = '{4'b1000, 4'b0010, 3'b000, 4'b0010, 1'b0, 4'b0000, 4'b0000, 4'b0000};
        tbl[18] = '{4'b1000, 4'b0010, 3'b000, 4'b0010, 1'b0, 4'b0000, 4'b0000, 4'b0000};
        tbl[19] = '{4'b1010, 4'b0010, 3'b100, 4'b0010, 1'b1, 4'b0000, 4'b0000, 4'b0010};
        tbl[20] = '{4'b1000, 4'b0000, 3'b000, 4'b0010, 1'b0, 4'b0000, 4'b0000, 4'b0000};
        tbl[21] = '{4'b1000, 4'b0000, 3'b010, 4'b1000, 1'b1, 4'b0000, 4'b1000, 4'b0000};
        tbl[22] = '{4'b0000, 4'b0000, 3'b000, 4'b1000, 1'b0, 4'b0000, 4'b0000, 4'b0000};
        tbl[23] = '{4'b0000, 4'b0000, 3'b000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000};
        for (int r = 0; r < 24; r++) begin
            cyc = tbl[r].cyc;
            stb = tbl[r].cyc;
            lock = tbl[r].lock;
            {srty, serr, sack} = tbl[r].rsp;
            ea = '0;
            for (int i = 0; i < N; i++)
                if (tbl[r].gnt[i]) ea = adr[i*AW +: AW];
            @(negedge clk);
            chk($sformatf("tbl%0d_gnt", r), gnt, tbl[r].gnt);
            chk($sformatf("tbl%0d_scyc", r), scyc, tbl[r].scyc);
            chk($sformatf("tbl%0d_sadr", r), sadr, ea);
            chk($sformatf("tbl%0d_ack", r), mack, tbl[r].ack);
            chk($sformatf("tbl%0d_err", r), merr, tbl[r].err);
            chk($sformatf("tbl%0d_rty", r), mrty, tbl[r].rty);
            chk($sformatf("tbl%0d_tmo", r), tmo, 0);
            tick();
        end

        // watchdog: slave silent, ERR on the 9th strobe cycle, then held in abort
        do_reset();
        cyc = 4'b0100;
        stb = 4'b0100;
        tick();
        for (int s = 1; s <= 9; s++) begin
            @(negedge clk);
            chk($sformatf("wd%0d_err", s), merr, (s == 9) ? 4'b0100 : 4'b0000);
            chk($sformatf("wd%0d_tmo", s), tmo, s == 9);
            chk($sformatf("wd%0d_scyc", s), scyc, 1);
            tick();
        end
        for (int s = 10; s <= 12; s++) begin
            @(negedge clk);
            chk($sformatf("wd%0d_scyc", s), scyc, 0);
            chk($sformatf("wd%0d_sstb", s), sstb, 0);
            chk($sformatf("wd%0d_gnt", s), gnt, 4'b0100);
            chk($sformatf("wd%0d_err", s), merr, 0);
            chk($sformatf("wd%0d_tmo", s), tmo, 0);
            tick();
        end
        cyc = '0;
        stb = '0;
        lock = 4'b0100;
        @(negedge clk);
        chk("wd_drop_gnt", gnt, 4'b0100);
        tick();
        @(negedge clk);
        chk("wd_release_gnt", gnt, 0);
        lock = '0;
        tick();

        // race: ACK arrives in the cycle the counter hits the limit
        do_reset();
        cyc = 4'b0010;
        stb = 4'b0010;
        tick();
        for (int s = 1; s <= 9; s++) begin
            sack = (s == 9);
            @(negedge clk);
            chk($sformatf("race%0d_ack", s), mack, (s == 9) ? 4'b0010 : 4'b0000);
            chk($sformatf("race%0d_err", s), merr, 0);
            chk($sformatf("race%0d_tmo", s), tmo, 0);
            tick();
        end
        sack = 1'b0;
        @(negedge clk);
        chk("race_after_scyc", scyc, 1);
        chk("race_after_gnt", gnt, 4'b0010);
        tick();
        cyc = '0;
        stb = '0;
        tick();

        // reset mid-transfer clears everything at once and restarts at master 0
        do_reset();
        cyc = 4'b1000;
        stb = 4'b1000;
        tick();
        @(negedge clk);
        chk("mid_gnt_before", gnt, 4'b1000);
        chk("mid_scyc_before", scyc, 1);
        sack = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("mid_gnt", gnt, 0);
        chk("mid_scyc", scyc, 0);
        chk("mid_sstb", sstb, 0);
        chk("mid_sadr", sadr, 0);
        chk("mid_ack", mack, 0);
        chk("mid_tmo", tmo, 0);
        tick();
        sack = 1'b0;
        cyc = '1;
        stb = '1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_idle_gnt", gnt, 0);
        tick();
        @(negedge clk);
        chk("mid_first_gnt", gnt, 4'b0001);
        chk("mid_first_sadr", sadr, adr[0 +: AW]);
        tick();

        // randomized traffic against the reference model
        do_reset();
        o_own = -1;
        o_last = N - 1;
        o_stall = 0;
        o_abt = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < N; i++) begin
                cyc[i] = cyc[i] ? ($urandom_range(15) != 0) : ($urandom_range(3) == 0);
                stb[i] = cyc[i] && ($urandom_range(15) != 0);
                lock[i] = ($urandom_range(3) == 0);
                we[i] = 1'($urandom);
                adr[i*AW +: AW] = $urandom;
                sel[i*SW +: SW] = 8'($urandom);
                dat[i*DW +: DW] = {$urandom, $urandom};
                tgd[i*TW +: TW] = 16'($urandom);
            end
            sdat_i = {$urandom, $urandom};
            stgd_i = 16'($urandom);
            case ($urandom_range(47))
                0: {sack, serr, srty} = 3'b100;
                1: {sack, serr, srty} = 3'b010;
                2: {sack, serr, srty} = 3'b001;
                default: {sack, serr, srty} = 3'b000;
            endcase
            @(negedge clk);
            model_check();
            @(posedge clk);
            model_step();
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
